// File: rtl/load_bin_if.sv
// load_bin_if: start/done handshake plus clause/variable RAM read and core write ports of the bin loader.
interface load_bin_if #(
  parameter int WIDTH_BIN_ID  = 10,
  parameter int WIDTH_CLAUSES = 16,
  parameter int WIDTH_VAR     = 24,
  parameter int NUM_C         = 8,
  parameter int NUM_V         = 8
);
   localparam int CW = $clog2(NUM_C);
   localparam int VW = $clog2(NUM_V);
   logic                       start_load_i;
   logic [WIDTH_BIN_ID-1:0]    request_bin_num_i;
   logic                       done_load_o;
   logic                       busy_o;
   logic                       rd_c_en_o;
   logic [WIDTH_BIN_ID+CW-1:0] rd_c_addr_o;
   logic [WIDTH_CLAUSES-1:0]   rd_c_data_i;
   logic                       rd_v_en_o;
   logic [WIDTH_BIN_ID+VW-1:0] rd_v_addr_o;
   logic [WIDTH_VAR-1:0]       rd_v_data_i;
   logic                       wr_c_o;
   logic [CW-1:0]              wr_c_idx_o;
   logic [WIDTH_CLAUSES-1:0]   wr_c_data_o;
   logic                       wr_v_o;
   logic [VW-1:0]              wr_v_idx_o;
   logic [WIDTH_VAR-1:0]       wr_v_data_o;
   modport slave (
      input  start_load_i, request_bin_num_i, rd_c_data_i, rd_v_data_i,
      output done_load_o, busy_o, rd_c_en_o, rd_c_addr_o, rd_v_en_o, rd_v_addr_o,
             wr_c_o, wr_c_idx_o, wr_c_data_o, wr_v_o, wr_v_idx_o, wr_v_data_o
   );
   modport master (
      output start_load_i, request_bin_num_i, rd_c_data_i, rd_v_data_i,
      input  done_load_o, busy_o, rd_c_en_o, rd_c_addr_o, rd_v_en_o, rd_v_addr_o,
             wr_c_o, wr_c_idx_o, wr_c_data_o, wr_v_o, wr_v_idx_o, wr_v_data_o
   );
endinterface

// File: rtl/load_bin.sv
// load_bin: streams one bin's clauses then variables from RAM into the core, one word per cycle.
module load_bin #(
  parameter int WIDTH_BIN_ID  = 10,
  parameter int WIDTH_CLAUSES = 16,
  parameter int WIDTH_VAR     = 24,
  parameter int NUM_C         = 8,
  parameter int NUM_V         = 8
) (
   input  logic       clk,
   input  logic       rst,
   load_bin_if.slave  bus
);
   localparam int CW = $clog2(NUM_C);
   localparam int VW = $clog2(NUM_V);
   typedef enum logic [1:0] {IDLE, RD_C, RD_V, DONE} state_t;
   state_t                  state, state_nx;
   logic [WIDTH_BIN_ID-1:0] bin_r;
   logic [CW-1:0]           ci, wc_idx;
   logic [VW-1:0]           vi, wv_idx;
   logic                    wc, wv, rc_en, rv_en, c_last, v_last;
   assign rc_en  = state == RD_C;
   assign rv_en  = state == RD_V;
   assign c_last = ci == CW'(NUM_C - 1);
   assign v_last = vi == VW'(NUM_V - 1);
   always_comb begin
      state_nx = (state == IDLE) ? (bus.start_load_i ? RD_C : IDLE) :
                 (state == RD_C) ? (c_last ? RD_V : RD_C) :
                 (state == RD_V) ? (v_last ? DONE : RD_V) : IDLE;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end
   // Write side is the read side delayed one cycle, matching RAM read latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_r  <= '0;
         ci     <= '0;
         vi     <= '0;
         wc     <= 1'b0;
         wv     <= 1'b0;
         wc_idx <= '0;
         wv_idx <= '0;
      end else begin
         if (state == IDLE && bus.start_load_i) begin
            bin_r <= bus.request_bin_num_i;
            ci    <= '0;
            vi    <= '0;
         end
         if (rc_en) ci <= c_last ? '0 : ci + 1'b1;
         if (rv_en) vi <= v_last ? '0 : vi + 1'b1;
         wc     <= rc_en;
         wv     <= rv_en;
         wc_idx <= rc_en ? ci : '0;
         wv_idx <= rv_en ? vi : '0;
      end
   end
   assign bus.busy_o      = state != IDLE;
   assign bus.done_load_o = state == DONE;
   assign bus.rd_c_en_o   = rc_en;
   assign bus.rd_v_en_o   = rv_en;
   assign bus.rd_c_addr_o = rc_en ? {bin_r, ci} : '0;
   assign bus.rd_v_addr_o = rv_en ? {bin_r, vi} : '0;
   assign bus.wr_c_o      = wc;
   assign bus.wr_v_o      = wv;
   assign bus.wr_c_idx_o  = wc_idx;
   assign bus.wr_v_idx_o  = wv_idx;
   assign bus.wr_c_data_o = wc ? bus.rd_c_data_i : '0;
   assign bus.wr_v_data_o = wv ? bus.rd_v_data_i : '0;
endmodule

// File: tb/tb_load_bin.sv
// tb_load_bin: scoreboard bench for load_bin; expected RAM reads, core writes and done are queued per start.
module tb_load_bin;
   localparam int BW = 10, CD = 16, VD = 24, NC = 8, NV = 8;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   load_bin_if #(.WIDTH_BIN_ID(BW), .WIDTH_CLAUSES(CD), .WIDTH_VAR(VD), .NUM_C(NC), .NUM_V(NV)) bus ();
   load_bin #(.WIDTH_BIN_ID(BW), .WIDTH_CLAUSES(CD), .WIDTH_VAR(VD), .NUM_C(NC), .NUM_V(NV)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   typedef struct {int cyc; int val; int idx;} ev_t;
   ev_t q_rc[$], q_rv[$], q_wc[$], q_wv[$];
   int  q_done[$];
   ev_t e;
   int  cyc = 0, n_vec = 0, n_err = 0;
   always @(posedge clk) cyc <= cyc + 1;
   // RAM models: clause word = addr*7, variable word = addr*13+5.
   always @(posedge clk) begin
      bus.rd_c_data_i <= bus.rd_c_en_o ? CD'(bus.rd_c_addr_o * 7) : '0;
      bus.rd_v_data_i <= bus.rd_v_en_o ? VD'(bus.rd_v_addr_o * 13 + 5) : '0;
   end
   task automatic check(string tag, longint obs, longint exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.rd_c_en_o) begin
         if (q_rc.size() == 0) check("rc_extra", 1, 0);
         else begin e = q_rc.pop_front(); check("rc_cyc", cyc, e.cyc); check("rc_addr", bus.rd_c_addr_o, e.val); end
      end
      if (bus.rd_v_en_o) begin
         if (q_rv.size() == 0) check("rv_extra", 1, 0);
         else begin e = q_rv.pop_front(); check("rv_cyc", cyc, e.cyc); check("rv_addr", bus.rd_v_addr_o, e.val); end
      end
      if (bus.wr_c_o) begin
         if (q_wc.size() == 0) check("wc_extra", 1, 0);
         else begin
            e = q_wc.pop_front();
            check("wc_cyc", cyc, e.cyc); check("wc_idx", bus.wr_c_idx_o, e.idx); check("wc_data", bus.wr_c_data_o, e.val);
         end
      end
      if (bus.wr_v_o) begin
         if (q_wv.size() == 0) check("wv_extra", 1, 0);
         else begin
            e = q_wv.pop_front();
            check("wv_cyc", cyc, e.cyc); check("wv_idx", bus.wr_v_idx_o, e.idx); check("wv_data", bus.wr_v_data_o, e.val);
         end
      end
      if (bus.done_load_o) begin
         if (q_done.size() == 0) check("done_extra", 1, 0);
         else begin check("done_cyc", cyc, q_done.pop_front()); check("busy_at_done", bus.busy_o, 1); end
      end
   end
   task automatic push(int b, int c);
      for (int k = 0; k < NC; k++) begin
         q_rc.push_back('{c + 1 + k, b * NC + k, k});
         q_wc.push_back('{c + 2 + k, ((b * NC + k) * 7) & 16'hFFFF, k});
      end
      for (int k = 0; k < NV; k++) begin
         q_rv.push_back('{c + NC + 1 + k, b * NV + k, k});
         q_wv.push_back('{c + NC + 2 + k, ((b * NV + k) * 13 + 5) & 24'hFFFFFF, k});
      end
      q_done.push_back(c + NC + NV + 1);
   endtask
   task automatic pulse(int b);
      bus.start_load_i      = 1'b1;
      bus.request_bin_num_i = BW'(b);
      @(negedge clk); #1;
      bus.start_load_i      = 1'b0;
      bus.request_bin_num_i = '0;
   endtask
   task automatic load(int b, output int c);
      @(negedge clk); #1;
      c = cyc;
      push(b, c);
      pulse(b);
   endtask
   task automatic drain(string tag);
      for (int i = 0; i < 40 && q_done.size() > 0; i++) begin @(negedge clk); #2; end
      check(tag, q_done.size(), 0);
   endtask
   task automatic chk_zero(string p);
      check({p, "_busy"}, bus.busy_o, 0);
      check({p, "_done"}, bus.done_load_o, 0);
      check({p, "_rc_en"}, bus.rd_c_en_o, 0);
      check({p, "_rc_addr"}, bus.rd_c_addr_o, 0);
      check({p, "_rv_en"}, bus.rd_v_en_o, 0);
      check({p, "_rv_addr"}, bus.rd_v_addr_o, 0);
      check({p, "_wc"}, bus.wr_c_o, 0);
      check({p, "_wc_data"}, bus.wr_c_data_o, 0);
      check({p, "_wv"}, bus.wr_v_o, 0);
      check({p, "_wv_data"}, bus.wr_v_data_o, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      int c;
      bus.start_load_i      = 1'b0;
      bus.request_bin_num_i = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1 chk_zero("por");
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      load(3, c);
      repeat (5) @(negedge clk);
      #1 pulse(9);
      drain("drain_bin3");
      load(5, c);
      repeat (16) @(negedge clk);
      #3 pulse(9);
      drain("drain_bin5");
      repeat (3) @(negedge clk);
      #1 check("idle_after_done_start", bus.busy_o, 0);
      load(1023, c);
      drain("drain_bin1023");
      load(4, c);
      drain("drain_b2b_a");
      load(6, c);
      drain("drain_b2b_b");
      load(7, c);
      repeat (5) @(negedge clk);
      #1 rst = 1'b0;
      q_rc.delete(); q_rv.delete(); q_wc.delete(); q_wv.delete(); q_done.delete();
      #1 chk_zero("mid_rst");
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      load(2, c);
      drain("drain_bin2");
      repeat (4) @(negedge clk);
      #1 check("queues_left", q_rc.size() + q_rv.size() + q_wc.size() + q_wv.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
